// File: rtl/pipo_arb_pkg.sv
// Shared types and constants for the PIPO write arbiter.
package pipo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        COMMIT = 2'd2
    } arb_state_t;

    localparam int CNT_W = 8;

endpackage

// File: rtl/pipo_write_arbiter_rr_pick.sv
// Round-robin picker: returns the first asserted request at or above rr_ptr,
// wrapping past the top index back to zero.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Scan from the farthest offset down to offset 0 so the closest request to rr_ptr wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        valid = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int                 c;
            logic [IDX_W-1:0]   cand;
            c = int'(rr_ptr) + k;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            cand = IDX_W'(c);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/pipo_write_arbiter.sv
// Round-robin write controller sharing one PIPO data register between NUM_REQ requesters.
// IDLE picks a winner and latches its data, GRANT waits one cycle, COMMIT strobes the
// register and acks the winner. One write every three cycles at most.
module pipo_write_arbiter
    import pipo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        reg_load,
    output logic [DATA_W-1:0]           reg_data,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  last_owner,
    output logic [CNT_W-1:0]            write_count
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic [DATA_W-1:0]  grant_data;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    // State sequencing: IDLE -> GRANT -> COMMIT -> IDLE, leaving IDLE only on a pick.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (pick_valid) state <= GRANT;
                GRANT:   state <= COMMIT;
                COMMIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Capture the winner and its data at the IDLE->GRANT edge; later wdata changes are ignored.
    always_ff @(posedge clk) begin
        // NOTE: pure datapath capture, never read before being loaded, so it carries no reset.
        if (state == IDLE && pick_valid) begin
            grant_idx  <= pick_idx;
            grant_data <= wdata[pick_idx*DATA_W +: DATA_W];
        end
    end

    // Present latched data to the register for COMMIT and hold it afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_data <= '0;
        end else if (state == GRANT) begin
            reg_data <= grant_data;
        end
    end

    // Bookkeeping on each committed write; the winner drops to lowest priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner  <= '0;
            write_count <= '0;
            rr_ptr      <= '0;
        end else if (state == COMMIT) begin
            last_owner  <= grant_idx;
            write_count <= write_count + 1'b1;
            if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + 1'b1;
            end
        end
    end

    // Load strobe and one-hot ack come straight from COMMIT so they always coincide.
    always_comb begin
        reg_load = (state == COMMIT);
        busy     = (state != IDLE);
        ack      = '0;
        if (state == COMMIT) begin
            ack[grant_idx] = 1'b1;
        end
    end

endmodule
